cp0_exception_controller: RTL

Coprocessor-0 controller for the MIPS core. It holds the Status, Cause, EPC, Count and Compare registers and sequences them. It serves MTC0 writes from writeback and MFC0 reads, and commits exceptions and ERET from writeback. It samples hardware interrupts, runs the Count/Compare timer, and issues a one-cycle pipeline flush with a redirect target. It sits beside the writeback stage and drives fetch redirection.

---
 rtl/cp0_exception_controller.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/cp0_exception_controller.sv
// Coprocessor-0 exception controller: Status/Cause/EPC/Count/Compare, interrupt and timer logic.
// Latency: MTC0, exception and ERET update state one cycle after commit; read_data is combinational.
// No backpressure: every commit is accepted in its cycle; lower-priority events in that cycle are dropped.

package cp0_pkg;

    typedef struct packed {
        logic [4:0]  register;
        logic [2:0]  select;
        logic        write_enabled;
        logic [31:0] write_data;
    } wb_to_cp0_t;

    typedef struct packed {
        logic [8:0]  zero_31_23;
        logic        bev;
        logic [5:0]  zero_21_16;
        logic [7:0]  im;
        logic [5:0]  zero_7_2;
        logic        exl;
        logic        ie;
    } status_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] zero_29_16;
        logic [5:0]  hardware_interrupt;
        logic [1:0]  software_interrupt;
        logic        zero_7;
        logic [4:0]  exc_code;
        logic [1:0]  zero_1_0;
    } cause_t;

endpackage

module cp0_exception_controller
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXCEPTION_VECTOR = 32'hBFC00380,
    parameter logic [31:0] STATUS_RESET     = 32'h00400000
) (
    input  logic        clock,
    input  logic        reset,
    input  wb_to_cp0_t  wb_to_cp0,
    input  logic [4:0]  read_register,
    input  logic [2:0]  read_select,
    output logic [31:0] read_data,
    input  logic        exception_valid,
    input  logic [4:0]  exception_code,
    input  logic [31:0] exception_pc,
    input  logic        exception_in_delay_slot,
    input  logic        eret_valid,
    input  logic [5:0]  hardware_interrupt,
    output logic        interrupt_pending,
    output logic        flush,
    output logic [31:0] flush_target,
    output status_t     status,
    output cause_t      cause,
    output logic [31:0] epc
);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    status_t     status_q;
    cause_t      cause_q;
    logic [31:0] epc_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        tick_q;
    logic        flush_q;
    logic [31:0] flush_target_q;

    // MTC0 only takes effect when no exception or ERET commits in the same cycle.
    logic        mtc0_en;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic        timer_hit;
    logic [7:0]  irq_lines;

    assign mtc0_en    = wb_to_cp0.write_enabled & ~exception_valid & ~eret_valid;
    assign wr_count   = mtc0_en && wb_to_cp0.register == REG_COUNT   && wb_to_cp0.select == 3'd0;
    assign wr_compare = mtc0_en && wb_to_cp0.register == REG_COMPARE && wb_to_cp0.select == 3'd0;
    assign wr_status  = mtc0_en && wb_to_cp0.register == REG_STATUS  && wb_to_cp0.select == 3'd0;
    assign wr_cause   = mtc0_en && wb_to_cp0.register == REG_CAUSE   && wb_to_cp0.select == 3'd0;
    assign wr_epc     = mtc0_en && wb_to_cp0.register == REG_EPC     && wb_to_cp0.select == 3'd0;

    // A Compare of zero disables the timer match.
    assign timer_hit  = (count_q == compare_q) && (compare_q != 32'd0);

    // Line 7 is shared between hardware interrupt 5 and the timer, as on MIPS32.
    assign irq_lines  = {cause_q.hardware_interrupt[5] | cause_q.ti,
                         cause_q.hardware_interrupt[4:0],
                         cause_q.software_interrupt};

    assign interrupt_pending = status_q.ie & ~status_q.exl & (|(irq_lines & status_q.im));

    assign flush        = flush_q;
    assign flush_target = flush_target_q;
    assign status       = status_q;
    assign cause        = cause_q;
    assign epc          = epc_q;

    // MFC0 read mux over registered state; unmapped addresses read zero.
    always_comb begin
        read_data = 32'd0;
        if (read_select == 3'd0) begin
            case (read_register)
                REG_COUNT:   read_data = count_q;
                REG_COMPARE: read_data = compare_q;
                REG_STATUS:  read_data = status_q;
                REG_CAUSE:   read_data = cause_q;
                REG_EPC:     read_data = epc_q;
                default:     read_data = 32'd0;
            endcase
        end
    end

    // All CP0 state: timer, interrupt sampling, commits and flush generation.
    always_ff @(posedge clock) begin
        if (reset) begin
            status_q       <= STATUS_RESET;
            cause_q        <= '0;
            epc_q          <= 32'd0;
            count_q        <= 32'd0;
            compare_q      <= 32'd0;
            tick_q         <= 1'b0;
            flush_q        <= 1'b0;
            flush_target_q <= 32'd0;
        end else begin
            cause_q.hardware_interrupt <= hardware_interrupt;

            // Count advances every other cycle; a Count write restarts the phase.
            if (wr_count) begin
                count_q <= wb_to_cp0.write_data;
                tick_q  <= 1'b0;
            end else begin
                tick_q <= ~tick_q;
                if (tick_q) begin
                    count_q <= count_q + 32'd1;
                end
            end

            // A Compare write acknowledges the timer and beats a same-cycle match.
            if (wr_compare) begin
                compare_q  <= wb_to_cp0.write_data;
                cause_q.ti <= 1'b0;
            end else if (timer_hit) begin
                cause_q.ti <= 1'b1;
            end

            flush_q <= exception_valid | eret_valid;

            if (exception_valid) begin
                // Nested exceptions keep the original return point.
                if (!status_q.exl) begin
                    epc_q      <= exception_in_delay_slot ? exception_pc - 32'd4 : exception_pc;
                    cause_q.bd <= exception_in_delay_slot;
                end
                cause_q.exc_code <= exception_code;
                status_q.exl     <= 1'b1;
                flush_target_q   <= EXCEPTION_VECTOR;
            end else if (eret_valid) begin
                status_q.exl   <= 1'b0;
                flush_target_q <= epc_q;
            end else begin
                if (wr_status) begin
                    status_q.im  <= wb_to_cp0.write_data[15:8];
                    status_q.exl <= wb_to_cp0.write_data[1];
                    status_q.ie  <= wb_to_cp0.write_data[0];
                end
                if (wr_cause) begin
                    cause_q.software_interrupt <= wb_to_cp0.write_data[9:8];
                end
                if (wr_epc) begin
                    epc_q <= wb_to_cp0.write_data;
                end
            end
        end
    end

endmodule
